// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use interlock plus tracking of one outstanding mult/div with watchdog abort.
// stall/bubble/md_start are combinational from decode inputs and the registered mult/div state.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_is_md,
  input  logic [4:0]  id_md_rd,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        md_done,
  output logic        stall,
  output logic        bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic [4:0]  md_pending_rd,
  output logic        md_err,
  output logic [15:0] stall_cnt
);

  localparam int WDW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [4:0]       pend_q;
  logic [WDW-1:0]   wd_q;
  logic             err_q;
  logic [15:0]      cnt_q, cnt_d;
  logic             load_use, md_haz, stall_w, start_w;

  // Register 0 is hardwired, so it never carries a dependency.
  function automatic logic reads_reg(input logic [4:0] r);
    return (r != 5'd0) && ((id_use_rs && (id_rs == r)) || (id_use_rt && (id_rt == r)));
  endfunction

  always_comb begin
    load_use = id_valid && ex_is_load && reads_reg(ex_rd);
    md_haz   = (state_q == BUSY) && id_valid && (id_is_md || reads_reg(pend_q));
    stall_w  = !reset && (load_use || md_haz);
    start_w  = !reset && (state_q == IDLE) && id_valid && id_is_md && !load_use;
    cnt_d    = cnt_q;
    if (stall_w && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 5'd0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (start_w) begin
            state_q <= BUSY;
            pend_q  <= id_md_rd;
            wd_q    <= '0;
          end
        end
        BUSY: begin
          if (md_done) begin
            state_q <= IDLE;
            pend_q  <= 5'd0;
            wd_q    <= '0;
          end else if (wd_q == WDW'(MD_TIMEOUT - 1)) begin
            state_q <= IDLE;
            pend_q  <= 5'd0;
            wd_q    <= '0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall         = stall_w;
  assign bubble        = stall_w;
  assign md_start      = start_w;
  assign md_busy       = (state_q == BUSY);
  assign md_pending_rd = pend_q;
  assign md_err        = err_q;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle sequences, random vs reference model.
module tb_hazard_ctrl;

  localparam int TMO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs, id_use_rt, id_is_md, ex_is_load, md_done;
  logic [4:0]  id_rs, id_rt, id_md_rd, ex_rd;
  logic        stall, bubble, md_start, md_busy, md_err;
  logic [4:0]  md_pending_rd;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state: busy flag, pending register, cycles already spent busy, sticky error, stall count.
  int m_busy, m_pend, m_age, m_err, m_cnt;
  int n_busy, n_pend, n_age, n_err, n_cnt;

  always #5 clock = ~clock;

  hazard_ctrl #(.MD_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_md(id_is_md), .id_md_rd(id_md_rd),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .md_done(md_done), .stall(stall), .bubble(bubble),
    .md_start(md_start), .md_busy(md_busy), .md_pending_rd(md_pending_rd), .md_err(md_err),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, is_md, ex_load;
    logic [4:0] ex_rd;
    logic       exp_stall, exp_start;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_in();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_is_md = 0; id_md_rd = 0; ex_is_load = 0; ex_rd = 0; md_done = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_age = 0; m_err = 0; m_cnt = 0;
  endtask

  function automatic bit reads(input int r);
    return (r != 0) && ((id_use_rs && int'(id_rs) == r) || (id_use_rt && int'(id_rt) == r));
  endfunction

  // Called at posedge+1; moves to the negedge, checks all outputs against the model, prepares next state.
  task automatic settle();
    bit lu, haz, e_stall, e_start;
    #4;
    lu      = id_valid && ex_is_load && reads(int'(ex_rd));
    haz     = (m_busy != 0) && id_valid && (id_is_md || reads(m_pend));
    e_stall = lu || haz;
    e_start = (m_busy == 0) && id_valid && id_is_md && !lu;
    checks++;
    if ({stall, bubble, md_start, md_busy, md_pending_rd, md_err, stall_cnt} !==
        {e_stall, e_stall, e_start, m_busy[0], m_pend[4:0], m_err[0], m_cnt[15:0]}) begin
      failures++;
      $display("FAIL model t=%0t: got st=%b bb=%b go=%b busy=%b rd=%0d err=%b cnt=%0d expected st=%b go=%b busy=%0d rd=%0d err=%0d cnt=%0d",
               $time, stall, bubble, md_start, md_busy, md_pending_rd, md_err, stall_cnt,
               e_stall, e_start, m_busy, m_pend, m_err, m_cnt);
    end
    n_busy = m_busy; n_pend = m_pend; n_age = m_age; n_err = m_err;
    n_cnt  = (e_stall && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    if (m_busy != 0) begin
      if (md_done) begin
        n_busy = 0; n_pend = 0; n_age = 0;
      end else if (m_age + 1 >= TMO) begin
        n_busy = 0; n_pend = 0; n_age = 0; n_err = 1;
      end else begin
        n_age = m_age + 1;
      end
    end else if (e_start) begin
      n_busy = 1; n_pend = int'(id_md_rd); n_age = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    m_busy = n_busy; m_pend = n_pend; m_age = n_age; m_err = n_err; m_cnt = n_cnt;
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1; #1; reset = 0;
    model_reset();
  endtask

  initial begin
    int busy_cycles;
    vecs[0] = '{1, 5, 0, 1, 0, 0, 1, 5, 1, 0};
    vecs[1] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    vecs[2] = '{1, 1, 7, 0, 1, 0, 1, 7, 1, 0};
    vecs[3] = '{1, 1, 7, 0, 0, 0, 1, 7, 0, 0};
    vecs[4] = '{1, 5, 0, 1, 0, 0, 0, 5, 0, 0};
    vecs[5] = '{0, 5, 0, 1, 0, 0, 1, 5, 0, 0};
    vecs[6] = '{1, 5, 0, 1, 0, 0, 1, 6, 0, 0};
    vecs[7] = '{1, 2, 3, 1, 1, 1, 1, 9, 0, 1};
    vecs[8] = '{1, 2, 9, 1, 1, 1, 1, 9, 1, 0};
    vecs[9] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 1};

    clr_in();
    reset = 1;
    id_valid = 1; id_rs = 5; id_use_rs = 1; ex_is_load = 1; ex_rd = 5;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_state", {md_busy, md_pending_rd, md_err, stall_cnt}, 0);
    clr_in(); id_valid = 1; id_is_md = 1; #1;
    chk("rst_start", md_start, 0);
    clr_in();
    @(posedge clock); #1;
    reset = 0;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      pulse_reset();
      id_valid = vecs[i].valid; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt; id_is_md = vecs[i].is_md;
      id_md_rd = 5'd4; ex_is_load = vecs[i].ex_load; ex_rd = vecs[i].ex_rd;
      #2;
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_bubble", i), bubble, vecs[i].exp_stall);
      chk($sformatf("vec%0d_start", i), md_start, vecs[i].exp_start);
      @(posedge clock); #1;
    end
    clr_in();
    pulse_reset();

    // Issue to r8, dependent reader waits until the cycle after md_done.
    id_valid = 1; id_is_md = 1; id_md_rd = 8;
    settle(); chk("issue_start", md_start, 1); tick();
    clr_in();
    settle(); chk("issue_busy", md_busy, 1); chk("issue_rd", md_pending_rd, 8); chk("issue_start_once", md_start, 0); tick();
    id_valid = 1; id_rs = 8; id_use_rs = 1;
    step(); step();
    md_done = 1;
    settle(); chk("done_cycle_stall", stall, 1); tick();
    md_done = 0;
    settle(); chk("after_done_stall", stall, 0); chk("after_done_busy", md_busy, 0); tick();
    clr_in();

    // md_done coinciding with a new issue.
    id_valid = 1; id_is_md = 1; id_md_rd = 3;
    step();
    id_md_rd = 9; md_done = 1;
    settle(); chk("coinc_stall", stall, 1); chk("coinc_start", md_start, 0); tick();
    md_done = 0;
    settle(); chk("coinc_reissue", md_start, 1); tick();
    clr_in();
    settle(); chk("coinc_rd", md_pending_rd, 9); tick();
    md_done = 1; step(); md_done = 0;
    md_done = 1; step(); md_done = 0;

    // Watchdog timeout.
    id_valid = 1; id_is_md = 1; id_md_rd = 12;
    step();
    clr_in();
    busy_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      settle();
      if (!md_busy) begin
        tick();
        break;
      end
      busy_cycles++;
      tick();
    end
    chk("tmo_busy_cycles", busy_cycles, TMO);
    chk("tmo_err", md_err, 1);
    step(); step();
    settle(); chk("tmo_err_sticky", md_err, 1); tick();

    // Reset while busy.
    id_valid = 1; id_is_md = 1; id_md_rd = 17;
    step();
    clr_in();
    step(); step();
    id_valid = 1; id_rs = 17; id_use_rs = 1;
    #2;
    reset = 1; #1;
    chk("rstbusy_busy", md_busy, 0);
    chk("rstbusy_rd", md_pending_rd, 0);
    chk("rstbusy_err", md_err, 0);
    chk("rstbusy_cnt", stall_cnt, 0);
    chk("rstbusy_stall", stall, 0);
    @(posedge clock); #1;
    reset = 0;
    model_reset();
    clr_in();

    for (int c = 0; c < 1500; c++) begin
      id_valid   = ($urandom_range(0, 7) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_use_rs  = 1'($urandom_range(0, 1));
      id_use_rt  = 1'($urandom_range(0, 1));
      id_is_md   = ($urandom_range(0, 3) == 0);
      id_md_rd   = 5'($urandom_range(0, 3));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_rd      = 5'($urandom_range(0, 3));
      md_done    = (c > 700) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0);
      step();
    end
    clr_in();

    // Saturation of the stall counter.
    pulse_reset();
    id_valid = 1; id_rs = 5; id_use_rs = 1; ex_is_load = 1; ex_rd = 5;
    for (int c = 0; c < 65540; c++) begin
      step();
    end
    settle(); chk("sat_cnt", stall_cnt, 16'hFFFF); tick();
    clr_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 40: max cycles waited for md_done before abort.
REQ-002 SHALL have ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs  in  5  decode source register A.
- id_rt  in  5  decode source register B.
- id_use_rs  in  1  decode instruction reads id_rs.
- id_use_rt  in  1  decode instruction reads id_rt.
- id_is_md  in  1  decode instruction is a mult/div issue.
- id_md_rd  in  5  destination of that mult/div.
- ex_is_load  in  1  execute stage holds a load.
- ex_rd  in  5  execute-stage destination.
- md_done  in  1  multdiv result ready (1-cycle pulse).
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  insert nop into ID/EX.
- md_start  out  1  start multdiv.
- md_busy  out  1  multdiv operation outstanding.
- md_pending_rd  out  5  destination of outstanding multdiv.
- md_err  out  1  sticky timeout flag.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-003 SHALL compare 5-bit register numbers by bitwise equality; register 0 SHALL never create a hazard.
REQ-004 SHALL compute combinationally: load_use = id_valid & ex_is_load & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-005 SHALL implement FSM states IDLE and BUSY; md_busy = (state==BUSY).
REQ-006 In BUSY, md_haz SHALL be 1 when id_valid and either (a) a used source (id_rs/id_rt with use flag) equals md_pending_rd, which is nonzero, or (b) id_is_md=1.
REQ-007 SHALL drive stall = bubble = load_use | md_haz, combinationally, same cycle.
REQ-008 In IDLE, when id_valid & id_is_md & ~load_use, md_start SHALL be 1 combinationally that cycle; at the next edge, state=BUSY and md_pending_rd=id_md_rd, and the watchdog SHALL clear to 0.
REQ-009 md_start SHALL be 0 in BUSY and whenever load_use=1.
REQ-010 In BUSY, md_done=1 SHALL return state to IDLE at the next edge and clear md_pending_rd to 0.
REQ-011 md_haz SHALL stay asserted in the md_done cycle; a dependent instruction SHALL proceed in the following cycle.
REQ-012 If md_done and a new mult/div coincide in BUSY, the cycle SHALL stall; the issue SHALL occur from IDLE next cycle (md_start then).
REQ-013 md_done in IDLE SHALL be ignored.
REQ-014 Watchdog: a counter SHALL increment each cycle in BUSY without md_done.
REQ-015 When the watchdog reaches MD_TIMEOUT-1 without md_done, at the next edge: state=IDLE, md_pending_rd=0, md_err=1.
REQ-016 md_err SHALL stay 1 until reset.
REQ-017 stall_cnt SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.
REQ-018 Input changes outside the states above SHALL have no effect on state.

Reset
REQ-019 Reset SHALL asynchronously force: state=IDLE, md_pending_rd=0, watchdog=0, md_err=0, stall_cnt=0.
REQ-020 While reset=1, stall, bubble and md_start SHALL be 0.
REQ-021 Reset in BUSY SHALL abandon the operation with no md_err.

Verification
REQ-022 SHALL cover these directed scenarios:
- Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_use_rs=1 -> stall=bubble=1 same cycle; with ex_rd=0 -> stall=0.
- Issue: mult/div with id_md_rd=8 in IDLE -> md_start=1 one cycle, then md_busy=1, md_pending_rd=8; reader of r8 stalls until the cycle after md_done.
- Done plus issue: md_done and a new mult/div in the same cycle -> stall=1; next cycle md_start=1 and md_pending_rd updated.
- Timeout: MD_TIMEOUT=40, no md_done -> md_busy falls after 40 BUSY cycles; md_err=1 and stays 1.
- Reset mid-BUSY: reset asserted -> md_busy=0, md_pending_rd=0, md_err=0, stall_cnt=0 immediately.
- Saturation: 65540 stall cycles -> stall_cnt=16'hFFFF.
